// File: rtl/tap_pkg.sv
// Shared definitions for the TAP deck sequencer and the playback engine.
package tap_pkg;

    localparam int ADDR_W = 16;
    localparam int PAUSE_W = 22;
    localparam int unsigned PAUSE_CYCLES_DEF = 3500000;

    // Engine bit timing in clock cycles at 3.5 MHz
    localparam int unsigned PILOT_PULSE = 2168;
    localparam int unsigned PILOT_HDR = 8063;
    localparam int unsigned PILOT_DATA = 3223;
    localparam int unsigned SYNC1_PULSE = 667;
    localparam int unsigned SYNC2_PULSE = 735;
    localparam int unsigned BIT0_PULSE = 855;
    localparam int unsigned BIT1_PULSE = 1710;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_HDR_CAP,
        ST_CHECK,
        ST_START,
        ST_PLAY,
        ST_PAUSE,
        ST_END
    } deck_state_e;

    typedef enum logic [1:0] {
        CLS_HOST,
        CLS_HDR,
        CLS_PLAY
    } mem_cls_e;

    function automatic mem_cls_e state_class(input deck_state_e s);
        mem_cls_e c;
        c = CLS_HDR;
        if (s == ST_IDLE || s == ST_END) c = CLS_HOST;
        if (s == ST_PLAY) c = CLS_PLAY;
        return c;
    endfunction

endpackage

// File: rtl/tap_mem_mux.sv
// Tape memory port mux: host loader, deck header reads or playback engine.
module tap_mem_mux
    import tap_pkg::*;
(
    input  mem_cls_e          cls_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] hdr_addr_i,
    input  logic [ADDR_W-1:0] play_addr_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              host_gnt_o
);

    always_comb begin
        mem_addr_o = hdr_addr_i;
        host_gnt_o = 1'b0;
        unique case (cls_i)
            CLS_HOST: begin
                mem_addr_o = host_addr_i;
                host_gnt_o = host_req_i;
            end
            CLS_PLAY: mem_addr_o = play_addr_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/tap_deck.sv
// TAP block sequencer: walks block headers, launches the engine,
// inserts inter-block pauses and shares the tape RAM with the host.
module tap_deck
    import tap_pkg::*;
#(
    parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              cmd_rewind,
    input  logic [ADDR_W-1:0] image_len,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [7:0]        mem_data,
    output logic              mem_we,
    input  logic              host_req,
    output logic              host_gnt,
    input  logic [ADDR_W-1:0] host_address,
    input  logic              host_we,
    output logic              pl_start,
    output logic              pl_abort,
    output logic [ADDR_W-1:0] pl_addr,
    output logic [ADDR_W-1:0] pl_len,
    input  logic [ADDR_W-1:0] pl_rd_addr,
    input  logic              pl_done,
    output logic              playing,
    output logic              at_end,
    output logic              trunc_err,
    output logic [7:0]        block_num
);

    deck_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  cur_ptr_q, cur_ptr_d;
    logic [ADDR_W-1:0]  img_q, img_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic [PAUSE_W-1:0] pause_q, pause_d;
    logic [7:0]         block_q, block_d;
    logic               trunc_q, trunc_d;
    logic               abort_q, abort_d;
    logic [ADDR_W-1:0]  pl_addr_q, pl_addr_d;
    logic [ADDR_W-1:0]  pl_len_q, pl_len_d;

    // 17-bit sums so a block near the top of memory cannot wrap
    logic [ADDR_W:0] ptr2, ptr4, ptr_end, img_x, img_in_x;
    logic            active, engine_live, play_ok;
    logic [ADDR_W-1:0] hdr_addr;

    assign ptr2     = {1'b0, cur_ptr_q} + (ADDR_W+1)'(2);
    assign ptr4     = {1'b0, cur_ptr_q} + (ADDR_W+1)'(4);
    assign ptr_end  = ptr2 + {1'b0, len_q};
    assign img_x    = {1'b0, img_q};
    assign img_in_x = {1'b0, image_len};

    assign active = (state_q != ST_IDLE) && (state_q != ST_END);
    assign engine_live = (state_q == ST_START) || (state_q == ST_PLAY);
    assign play_ok = cmd_play && !cmd_stop && !cmd_rewind && !host_req;

    always_comb begin
        state_d   = state_q;
        cur_ptr_d = cur_ptr_q;
        img_d     = img_q;
        len_d     = len_q;
        pause_d   = pause_q;
        block_d   = block_q;
        trunc_d   = trunc_q;
        abort_d   = 1'b0;
        pl_addr_d = pl_addr_q;
        pl_len_d  = pl_len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (play_ok) begin
                    img_d = image_len;
                    state_d = (ptr2 > img_in_x) ? ST_END : ST_HDR_LO;
                end
            end
            ST_HDR_LO: state_d = ST_HDR_HI;
            ST_HDR_HI: begin
                len_d[7:0] = mem_data;
                state_d = ST_HDR_CAP;
            end
            ST_HDR_CAP: begin
                len_d[15:8] = mem_data;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (len_q == '0) begin
                    cur_ptr_d = ptr2[ADDR_W-1:0];
                    state_d = (ptr4 > img_x) ? ST_END : ST_HDR_LO;
                end else if (ptr_end > img_x) begin
                    trunc_d = 1'b1;
                    state_d = ST_END;
                end else begin
                    pl_addr_d = ptr2[ADDR_W-1:0];
                    pl_len_d = len_q;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_PLAY;
            ST_PLAY: begin
                if (pl_done) begin
                    cur_ptr_d = ptr_end[ADDR_W-1:0];
                    block_d = block_q + 8'd1;
                    pause_d = PAUSE_W'(PAUSE_CYCLES - 1);
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_q == '0) begin
                    state_d = (cur_ptr_q == img_q) ? ST_END : ST_HDR_LO;
                end else begin
                    pause_d = pause_q - PAUSE_W'(1);
                end
            end
            ST_END: ;
            default: state_d = ST_IDLE;
        endcase

        // Stop beats rewind; either one overrides the normal flow above
        if (cmd_stop) begin
            if (active) begin
                state_d = ST_IDLE;
                cur_ptr_d = cur_ptr_q;
                block_d = block_q;
                trunc_d = trunc_q;
                abort_d = engine_live;
            end
        end else if (cmd_rewind) begin
            state_d = ST_IDLE;
            cur_ptr_d = '0;
            block_d = '0;
            trunc_d = 1'b0;
            abort_d = engine_live;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_ptr_q <= '0;
            img_q     <= '0;
            len_q     <= '0;
            pause_q   <= '0;
            block_q   <= '0;
            trunc_q   <= 1'b0;
            abort_q   <= 1'b0;
            pl_addr_q <= '0;
            pl_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_ptr_q <= cur_ptr_d;
            img_q     <= img_d;
            len_q     <= len_d;
            pause_q   <= pause_d;
            block_q   <= block_d;
            trunc_q   <= trunc_d;
            abort_q   <= abort_d;
            pl_addr_q <= pl_addr_d;
            pl_len_q  <= pl_len_d;
        end
    end

    assign hdr_addr = (state_q == ST_HDR_LO) ? cur_ptr_q
                                             : cur_ptr_q + ADDR_W'(1);

    tap_mem_mux u_mux (
        .cls_i       (state_class(state_q)),
        .host_addr_i (host_address),
        .host_req_i  (host_req),
        .hdr_addr_i  (hdr_addr),
        .play_addr_i (pl_rd_addr),
        .mem_addr_o  (mem_address),
        .host_gnt_o  (host_gnt)
    );

    assign mem_we    = host_we & host_gnt;
    assign pl_start  = (state_q == ST_START);
    assign pl_abort  = abort_q;
    assign pl_addr   = pl_addr_q;
    assign pl_len    = pl_len_q;
    assign at_end    = (state_q == ST_END);
    assign trunc_err = trunc_q;
    assign block_num = block_q;
    assign playing   = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                       (state_q == ST_HDR_CAP) || (state_q == ST_START) ||
                       (state_q == ST_PLAY) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_tap_deck.sv
// Directed bench for tap_deck: scoreboard of expected engine launches
// plus inline checks of status, arbitration and reset behaviour.
module tb_tap_deck;
    import tap_pkg::*;

    localparam int P = 16;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              cmd_play = 1'b0;
    logic              cmd_stop = 1'b0;
    logic              cmd_rewind = 1'b0;
    logic [ADDR_W-1:0] image_len = '0;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_data = 8'h00;
    logic              mem_we;
    logic              host_req = 1'b0;
    logic              host_gnt;
    logic [ADDR_W-1:0] host_address = '0;
    logic              host_we = 1'b0;
    logic              pl_start;
    logic              pl_abort;
    logic [ADDR_W-1:0] pl_addr;
    logic [ADDR_W-1:0] pl_len;
    logic [ADDR_W-1:0] pl_rd_addr = '0;
    logic              pl_done = 1'b0;
    logic              playing;
    logic              at_end;
    logic              trunc_err;
    logic [7:0]        block_num;

    tap_deck #(.PAUSE_CYCLES(P)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_play     (cmd_play),
        .cmd_stop     (cmd_stop),
        .cmd_rewind   (cmd_rewind),
        .image_len    (image_len),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .host_req     (host_req),
        .host_gnt     (host_gnt),
        .host_address (host_address),
        .host_we      (host_we),
        .pl_start     (pl_start),
        .pl_abort     (pl_abort),
        .pl_addr      (pl_addr),
        .pl_len       (pl_len),
        .pl_rd_addr   (pl_rd_addr),
        .pl_done      (pl_done),
        .playing      (playing),
        .at_end       (at_end),
        .trunc_err    (trunc_err),
        .block_num    (block_num)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:255];
    always @(posedge clock) mem_data <= mem[mem_address[7:0]];

    typedef struct {
        logic [15:0] a;
        logic [15:0] l;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   total = 0;
    int   bad = 0;
    bit   in_play = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every engine launch is matched against the scoreboard
    always @(negedge clock) begin
        if (reset_n) begin
            if (pl_start) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected pl_start: got addr=%0h len=%0h want none",
                             pl_addr, pl_len);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("pl_addr", 32'(pl_addr), 32'(e_mon.a));
                    check("pl_len", 32'(pl_len), 32'(e_mon.l));
                end
            end
            if (in_play)
                check("play mem_address", 32'(mem_address), 32'(pl_rd_addr));
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] l);
        exp_t e;
        e.a = a;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input bit p, input bit s, input bit r);
        cmd_play = p;
        cmd_stop = s;
        cmd_rewind = r;
        @(posedge clock);
        #1;
        cmd_play = 1'b0;
        cmd_stop = 1'b0;
        cmd_rewind = 1'b0;
        if (s || r) in_play = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (pl_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: got no pl_start want pl_start", name);
        end
    endtask

    task automatic enter_play(input int n);
        @(posedge clock);
        #1;
        in_play = 1'b1;
        for (int i = 0; i < n; i++) begin
            pl_rd_addr = 16'h0100 + 16'(i);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic done_pulse();
        pl_done = 1'b1;
        @(posedge clock);
        #1;
        pl_done = 1'b0;
        in_play = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit ok;
        ok = at_end;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clock);
            #1;
            ok = at_end;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: got at_end=0 want 1", name);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " playing"}, 32'(playing), 0);
        check({tag, " at_end"}, 32'(at_end), 0);
        check({tag, " trunc_err"}, 32'(trunc_err), 0);
        check({tag, " block_num"}, 32'(block_num), 0);
        check({tag, " pl_start"}, 32'(pl_start), 0);
        check({tag, " pl_abort"}, 32'(pl_abort), 0);
        check({tag, " host_gnt"}, 32'(host_gnt), 0);
        check({tag, " mem_we"}, 32'(mem_we), 0);
        check({tag, " mem_address"}, 32'(mem_address), 0);
        check({tag, " pl_addr"}, 32'(pl_addr), 0);
        check({tag, " pl_len"}, 32'(pl_len), 0);
    endtask

    initial begin
        int n;
        clear_mem();
        #1 reset_n = 1'b0;
        #1 check_reset("por");
        #20 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single block 04 00 00 AA BB CC
        mem[0] = 8'h04; mem[1] = 8'h00; mem[2] = 8'h00;
        mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
        image_len = 16'd6;
        push(16'd2, 16'd4);
        pulse(1, 0, 0);
        wait_start("t1 start");
        enter_play(3);
        done_pulse();
        n = 0;
        while (!at_end && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("t1 pause cycles", 32'(n), 32'(P));
        check("t1 at_end", 32'(at_end), 1);
        check("t1 block_num", 32'(block_num), 1);
        check("t1 playing", 32'(playing), 0);
        pulse(1, 0, 0);
        check("t1 play ignored in end", 32'(at_end), 1);
        pulse(0, 0, 1);
        check("t1 rewind at_end", 32'(at_end), 0);
        check("t1 rewind block_num", 32'(block_num), 0);

        // Two blocks, len 19 then len 3
        clear_mem();
        mem[0] = 8'd19;
        for (int i = 2; i < 21; i++) mem[i] = 8'(8'h30 + i);
        mem[21] = 8'd3;
        mem[23] = 8'h77; mem[24] = 8'h88; mem[25] = 8'h99;
        image_len = 16'd26;
        push(16'd2, 16'd19);
        push(16'd23, 16'd3);
        pulse(1, 0, 0);
        wait_start("t2 start a");
        enter_play(4);
        done_pulse();
        check("t2 block_num a", 32'(block_num), 1);
        wait_start("t2 start b");
        enter_play(2);
        pulse(0, 1, 0);
        check("t2 stop abort", 32'(pl_abort), 1);
        check("t2 stop playing", 32'(playing), 0);
        check("t2 stop at_end", 32'(at_end), 0);
        check("t2 stop block_num", 32'(block_num), 1);
        host_req = 1'b1;
        #1 check("t2 gnt follows req", 32'(host_gnt), 1);
        host_address = 16'h0042;
        host_we = 1'b1;
        #1 check("t2 mem_we", 32'(mem_we), 1);
        check("t2 host mem_address", 32'(mem_address), 32'h42);
        host_we = 1'b0;
        host_address = '0;
        host_req = 1'b0;
        #1 check("t2 gnt released", 32'(host_gnt), 0);
        @(posedge clock);
        #1 check("t2 abort one cycle", 32'(pl_abort), 0);
        host_req = 1'b1;
        pulse(1, 0, 0);
        repeat (4) @(posedge clock);
        #1 check("t2 play blocked by host", 32'(playing), 0);
        host_req = 1'b0;
        push(16'd23, 16'd3);
        pulse(1, 0, 0);
        wait_start("t2 restart");
        enter_play(2);
        pulse(0, 1, 1);
        check("t2 stop+rewind abort", 32'(pl_abort), 1);
        check("t2 stop+rewind block_num", 32'(block_num), 1);
        check("t2 stop+rewind playing", 32'(playing), 0);
        push(16'd23, 16'd3);
        pulse(1, 0, 0);
        wait_start("t2 resume");
        enter_play(1);
        done_pulse();
        wait_end("t2 end");
        check("t2 block_num b", 32'(block_num), 2);
        pulse(0, 0, 1);

        // Zero-length block skipped
        clear_mem();
        mem[2] = 8'd2; mem[4] = 8'h11; mem[5] = 8'h22;
        image_len = 16'd6;
        push(16'd4, 16'd2);
        pulse(1, 0, 0);
        wait_start("t3 start");
        enter_play(2);
        done_pulse();
        wait_end("t3 end");
        check("t3 block_num", 32'(block_num), 1);
        check("t3 trunc_err", 32'(trunc_err), 0);
        pulse(0, 0, 1);

        // Truncated block
        clear_mem();
        mem[1] = 8'h01;
        image_len = 16'd10;
        pulse(1, 0, 0);
        wait_end("t4 end");
        check("t4 trunc_err", 32'(trunc_err), 1);
        check("t4 block_num", 32'(block_num), 0);
        pulse(0, 0, 1);
        check("t4 rewind trunc_err", 32'(trunc_err), 0);
        check("t4 rewind at_end", 32'(at_end), 0);

        // Asynchronous reset mid-pause
        mem[0] = 8'h04; mem[1] = 8'h00; mem[2] = 8'h00;
        mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
        image_len = 16'd6;
        push(16'd2, 16'd4);
        pulse(1, 0, 0);
        wait_start("t5 start");
        enter_play(2);
        done_pulse();
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 check("t5 in pause", 32'(playing), 1);
        check("t5 block_num pre", 32'(block_num), 1);
        reset_n = 1'b0;
        #1 check_reset("t5");
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1 check("t5 idle after reset", 32'(playing), 0);

        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
